bias_buffer_ld: RTL and testbench

- Loadable, registered successor to the fixed-constant bias ROM used by the LSTM/FC layers.
- Holds DEPTH rows of UNITS_NUM packed signed D_WL-bit biases; rows are loaded serially one element per cycle from the weight-load stream.
- Rows are read back through a 1-cycle registered request/valid port by the layer controller.
- Replaces per-network hard-coded tables so one netlist serves any trained model.

---
 rtl/nn_buf_pkg.sv | 24 ++
 rtl/bias_row_packer.sv | 42 ++++
 rtl/bias_buffer_ld.sv | 108 ++++++++++
 tb/tb_bias_buffer_ld.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_buf_pkg.sv
// rtl/nn_buf_pkg.sv - shared defaults, load FSM states and sizing helper for the NN buffers
package nn_buf_pkg;

    localparam int D_WL_DEF      = 24;
    localparam int UNITS_NUM_DEF = 5;
    localparam int DEPTH_DEF     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    // Never returns 0 so a single-entry counter still gets a 1-bit register.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_row_packer.sv
// rtl/bias_row_packer.sv - gathers serial bias elements into one row and strobes its commit
module bias_row_packer
    import nn_buf_pkg::*;
#(
    parameter int D_WL      = D_WL_DEF,
    parameter int UNITS_NUM = UNITS_NUM_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      beat,
    input  logic [D_WL-1:0]           data,
    output logic [UNITS_NUM*D_WL-1:0] row,
    output logic                      commit
);

    localparam int UW = clog2(UNITS_NUM);

    logic [UW-1:0]             unit_cnt;
    logic [UNITS_NUM*D_WL-1:0] shadow;

    // The committed row must already contain the final beat, so merge it combinationally.
    always_comb begin
        row = shadow;
        row[unit_cnt*D_WL +: D_WL] = data;
    end

    assign commit = beat && (unit_cnt == UW'(UNITS_NUM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_cnt <= '0;
            shadow   <= '0;
        end else if (clear) begin
            unit_cnt <= '0;
        end else if (beat) begin
            shadow   <= row;
            unit_cnt <= commit ? '0 : unit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bias_buffer_ld.sv
// rtl/bias_buffer_ld.sv - serially loadable bias row buffer with registered row read port
module bias_buffer_ld
    import nn_buf_pkg::*;
#(
    parameter int D_WL      = D_WL_DEF,
    parameter int UNITS_NUM = UNITS_NUM_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_start,
    input  logic                      ld_valid,
    input  logic [D_WL-1:0]           ld_data,
    output logic                      ld_ready,
    output logic                      ld_done,
    input  logic                      rd_req,
    input  logic [AW-1:0]             rd_addr,
    output logic                      rd_valid,
    output logic [UNITS_NUM*D_WL-1:0] rd_data,
    output logic                      rd_err
);

    localparam int RW = clog2(DEPTH);

    state_t                    state, next_state;
    logic [RW-1:0]             row_cnt;
    logic [UNITS_NUM*D_WL-1:0] row_w;
    logic                      commit;
    logic                      beat;
    logic                      rd_accept;
    logic                      last_row;
    logic [UNITS_NUM*D_WL-1:0] mem [DEPTH];

    // A coincident ld_start wins over ld_valid, so that beat is dropped.
    assign beat      = (state == LOAD) && ld_valid && !ld_start;
    assign last_row  = (row_cnt == RW'(DEPTH - 1));
    assign rd_accept = rd_req && ld_done;

    bias_row_packer #(
        .D_WL      (D_WL),
        .UNITS_NUM (UNITS_NUM)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (ld_start),
        .beat   (beat),
        .data   (ld_data),
        .row    (row_w),
        .commit (commit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        case (state)
            IDLE: ;
            LOAD: begin
                ld_ready = 1'b1;
                if (commit && last_row) next_state = READY;
            end
            READY:   ld_done = 1'b1;
            default: next_state = IDLE;
        endcase
        if (ld_start) next_state = LOAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
        end else if (ld_start) begin
            row_cnt <= '0;
        end else if (commit) begin
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[row_cnt] <= row_w;
    end

    // rd_data/rd_err only move on an accepted request and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                if (rd_addr >= AW'(DEPTH)) begin
                    rd_data <= '0;
                    rd_err  <= 1'b1;
                end else begin
                    rd_data <= mem[rd_addr[RW-1:0]];
                    rd_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bias_buffer_ld.sv
// tb/tb_bias_buffer_ld.sv - scoreboard testbench for bias_buffer_ld
module tb_bias_buffer_ld;

    localparam int D_WL = 24;
    localparam int UN   = 5;
    localparam int DEP  = 6;
    localparam int AW   = 8;
    localparam int RWID = UN * D_WL;
    localparam int NB   = DEP * UN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ld_start = 1'b0;
    logic            ld_valid = 1'b0;
    logic [D_WL-1:0] ld_data = '0;
    logic            ld_ready, ld_done;
    logic            rd_req = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_valid, rd_err;
    logic [RWID-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [D_WL-1:0]   elems [NB];
    logic [RWID-1:0]   ref_mem [DEP];
    logic [RWID:0]     exp_q [$];
    logic [RWID-1:0]   last_data;
    int                addr_q [$];

    always #5 clk = ~clk;

    bias_buffer_ld #(.D_WL(D_WL), .UNITS_NUM(UN), .DEPTH(DEP), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    // Read-response monitor: pops the scoreboard on every rd_valid, checks hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_data = '0;
        end else if (rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_spurious: rd_valid=1 with no request expected");
            end else begin
                logic [RWID:0] e;
                e = exp_q.pop_front();
                if ({rd_err, rd_data} !== e) begin
                    errors++;
                    $display("FAIL rd_resp: got err=%0b data=%h, want err=%0b data=%h",
                             rd_err, rd_data, e[RWID], e[RWID-1:0]);
                end
            end
            last_data = rd_data;
        end else begin
            checks++;
            if (rd_data !== last_data) begin
                errors++;
                $display("FAIL rd_hold: rd_data=%h, want held %h", rd_data, last_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input bit spec_row0);
        for (int i = 0; i < NB; i++) elems[i] = D_WL'($urandom);
        if (spec_row0) begin
            elems[0] = 24'h00C6AE; elems[1] = 24'h000975; elems[2] = 24'hFFF286;
            elems[3] = 24'hFFB2F4; elems[4] = 24'h00024B;
        end
    endtask

    // Drives ld_start then n beats; a full load also checks ld_done timing and updates the model.
    task automatic do_load(input int n, input bit rand_valid);
        int acc;
        int guard;
        acc = 0;
        guard = 0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        checks++;
        if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin
            errors++;
            $display("FAIL load_enter: ready=%0b done=%0b, want 1 0", ld_ready, ld_done);
        end
        while (acc < n && guard < 2000) begin
            ld_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = ld_valid ? elems[acc] : D_WL'($urandom);
            if (ld_valid) acc++;
            step();
            guard++;
            if (acc < NB) begin
                checks++;
                if (ld_done !== 1'b0 || ld_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL load_busy: done=%0b ready=%0b after %0d beats, want 0 1",
                             ld_done, ld_ready, acc);
                end
            end
        end
        ld_valid = 1'b0;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL load_timeout: only %0d beats accepted", acc);
        end
        if (n == NB) begin
            checks++;
            if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL load_done: done=%0b ready=%0b one cycle after last beat, want 1 0",
                         ld_done, ld_ready);
            end
            for (int r = 0; r < DEP; r++)
                for (int u = 0; u < UN; u++)
                    ref_mem[r][u*D_WL +: D_WL] = elems[r*UN + u];
        end
    endtask

    // Issues addr_q back to back; each accepted request must produce rd_valid the next cycle.
    task automatic issue_reads(input bit model_done);
        while (addr_q.size() > 0) begin
            int a;
            a = addr_q.pop_front();
            rd_req  = 1'b1;
            rd_addr = AW'(a);
            if (model_done)
                exp_q.push_back((a >= DEP) ? {1'b1, {RWID{1'b0}}} : {1'b0, ref_mem[a]});
            step();
            checks++;
            if (rd_valid !== model_done) begin
                errors++;
                $display("FAIL rd_valid_addr%0d: rd_valid=%0b, want %0b", a, rd_valid, model_done);
            end
        end
        rd_req = 1'b0;
        step();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_idle: rd_valid=%0b, want 0", rd_valid);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({ld_ready, ld_done, rd_valid, rd_err} !== 4'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b done=%0b valid=%0b err=%0b data=%h, want all 0",
                     ld_ready, ld_done, rd_valid, rd_err, rd_data);
        end
        rst = 1'b0;
        fill_random(1'b0);
        do_load(7, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ld_ready, ld_done, rd_valid, rd_err} !== 4'b0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_midload: ready=%0b done=%0b valid=%0b err=%0b data=%h, want all 0",
                     ld_ready, ld_done, rd_valid, rd_err, rd_data);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load_read();
        fill_random(1'b1);
        do_load(NB, 1'b0);
        addr_q = '{0};
        issue_reads(1'b1);
    endtask

    task automatic test_back_to_back();
        addr_q = '{5, 4, 3};
        issue_reads(1'b1);
        addr_q = '{0, 1, 2, 3, 4, 5};
        issue_reads(1'b1);
    endtask

    task automatic test_out_of_range();
        addr_q = '{6, 255, 2, 7};
        issue_reads(1'b1);
    endtask

    task automatic test_reload();
        // Read coincident with ld_start completes with the old row, then ld_done drops.
        rd_req = 1'b1;
        rd_addr = 8'd2;
        ld_start = 1'b1;
        exp_q.push_back({1'b0, ref_mem[2]});
        step();
        rd_req = 1'b0;
        ld_start = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || ld_done !== 1'b0) begin
            errors++;
            $display("FAIL start_with_read: valid=%0b done=%0b, want 1 0", rd_valid, ld_done);
        end
        addr_q = '{0, 1};
        issue_reads(1'b0);
        fill_random(1'b0);
        do_load(12, 1'b0);
        addr_q = '{0};
        issue_reads(1'b0);
        fill_random(1'b0);
        do_load(NB, 1'b0);
        addr_q = '{0, 1, 2, 3, 4, 5};
        issue_reads(1'b1);
    endtask

    task automatic test_random_valid();
        fill_random(1'b0);
        do_load(NB, 1'b1);
        addr_q = '{3, 1, 5, 0, 4, 2};
        issue_reads(1'b1);
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = D_WL'($urandom);
            step();
            checks++;
            if (ld_ready !== 1'b0 || ld_done !== 1'b1) begin
                errors++;
                $display("FAIL ready_ignore: ready=%0b done=%0b, want 0 1", ld_ready, ld_done);
            end
        end
        ld_valid = 1'b0;
        addr_q = '{0, 1, 2, 3, 4, 5};
        issue_reads(1'b1);
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_back_to_back();
        test_out_of_range();
        test_reload();
        test_random_valid();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
